slot_arbiter: RTL and testbench

- Round-robin time-slot arbiter that shares one resource among p_REQS requesters.
- Each grant lasts at most p_SLOT cycles. An optional guard gap of p_GUARD cycles separates consecutive grants.
- Slot timing comes from an internal period counter of the same style as the library period counters.
- Sits in front of any shared datapath (bus, UART TX, memory port) that needs bounded, fair access.

---
 rtl/slot_arbiter.sv | 164 ++++++++++++++++
 tb/tb_slot_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/slot_arbiter.sv
// slot_arbiter
//   Round-robin time-slot arbiter sharing one resource among p_REQS
//   requesters. A grant lasts until the owner drops its request or until
//   p_SLOT cycles have elapsed, whichever comes first. Optionally,
//   p_GUARD idle cycles are inserted between consecutive grants.
//
// Ports
//   i_clk         clock
//   w_reset       synchronous, active-high reset
//   iv_req        per-requester level request
//   ov_grant      registered one-hot grant; all zero when nobody owns the resource
//   ov_grant_idx  registered index of the current or most recent owner
//   o_busy        high while a grant is active
//   o_slot_end    high in the last cycle of a slot that ends by timeout
module slot_arbiter #(
  parameter int p_REQS  = 4,
  parameter int p_SLOT  = 8,
  parameter int p_GUARD = 1
) (
  input  logic                       i_clk,
  input  logic                       w_reset,
  input  logic [p_REQS-1:0]          iv_req,
  output logic [p_REQS-1:0]          ov_grant,
  output logic [$clog2(p_REQS)-1:0]  ov_grant_idx,
  output logic                       o_busy,
  output logic                       o_slot_end
);

  localparam int unsigned IW = $clog2(p_REQS);
  localparam int unsigned SW = $clog2(p_SLOT);
  localparam int unsigned GW = (p_GUARD > 0) ? $clog2(p_GUARD + 1) : 1;

  localparam logic [IW:0]   REQS_W     = (IW + 1)'(p_REQS);
  localparam logic [IW-1:0] LAST_REQ   = IW'(p_REQS - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(p_SLOT - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'((p_GUARD > 0) ? (p_GUARD - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GUARD
  } state_t;

  state_t            state_q, state_d;
  logic [p_REQS-1:0] grant_q, grant_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [GW-1:0]     guard_q, guard_d;

  // Circular priority scan starting at ptr_q.
  logic              found;
  logic [IW-1:0]     win;
  logic [IW-1:0]     win_next;
  logic [IW:0]       cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < p_REQS; i++) begin
      cand = {1'b0, ptr_q} + i[IW:0];
      if (cand >= REQS_W) begin
        cand = cand - REQS_W;
      end
      if (!found && iv_req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  assign win_next = (win == LAST_REQ) ? '0 : (win + IW'(1));

  // Slot-end conditions; timeout wins when both hold in the same cycle.
  logic timeout;
  logic release_req;
  logic load;

  assign timeout     = (state_q == ST_GRANT) && (slot_q == SLOT_LAST);
  assign release_req = (state_q == ST_GRANT) && !iv_req[idx_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    guard_d = guard_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load = found;
      end

      ST_GRANT: begin
        slot_d = slot_q + SW'(1);
        if (timeout || release_req) begin
          slot_d = '0;
          if (p_GUARD > 0) begin
            grant_d = '0;
            guard_d = '0;
            state_d = ST_GUARD;
          end else if (found) begin
            // No guard: hand over in the end cycle, using the ptr already
            // advanced past the current owner.
            load = 1'b1;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_GUARD: begin
        if (guard_q == GUARD_LAST) begin
          guard_d = '0;
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      grant_d      = '0;
      grant_d[win] = 1'b1;
      idx_d        = win;
      ptr_d        = win_next;
      slot_d       = '0;
      state_d      = ST_GRANT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      slot_q  <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      guard_q <= guard_d;
    end
  end

  assign ov_grant     = grant_q;
  assign ov_grant_idx = idx_q;
  assign o_busy       = (state_q == ST_GRANT);
  assign o_slot_end   = timeout;

endmodule

// File: tb/tb_slot_arbiter.sv
// tb_slot_arbiter
//   Directed bench for slot_arbiter. Instance u_a uses the defaults
//   (p_GUARD=1); instance u_b uses p_GUARD=0 for back-to-back hand-over.
module tb_slot_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] idx_a, idx_b;
  logic       busy_a, busy_b;
  logic       end_a, end_b;

  slot_arbiter #(.p_REQS(4), .p_SLOT(8), .p_GUARD(1)) u_a (
    .i_clk        (clk),
    .w_reset      (rst_a),
    .iv_req       (req_a),
    .ov_grant     (grant_a),
    .ov_grant_idx (idx_a),
    .o_busy       (busy_a),
    .o_slot_end   (end_a)
  );

  slot_arbiter #(.p_REQS(4), .p_SLOT(8), .p_GUARD(0)) u_b (
    .i_clk        (clk),
    .w_reset      (rst_b),
    .iv_req       (req_b),
    .ov_grant     (grant_b),
    .ov_grant_idx (idx_b),
    .o_busy       (busy_b),
    .o_slot_end   (end_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One row: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] idx;
    logic       busy;
    logic       send;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] g,
                              input logic [1:0] idx, input logic busy, input logic send);
    vec_t v;
    v.rst = rst; v.req = req; v.g = g; v.idx = idx; v.busy = busy; v.send = send;
    vecs.push_back(v);
  endfunction

  // Full 8-cycle timeout slot; o_slot_end only in the last cycle.
  function automatic void add_slot(input logic [3:0] req, input logic [3:0] g, input logic [1:0] idx);
    for (int c = 0; c < 8; c++) add(1'b0, req, g, idx, 1'b1, c == 7);
  endfunction

  // One GUARD cycle plus one IDLE cycle.
  function automatic void add_gap(input logic [3:0] req, input logic [1:0] idx);
    add(1'b0, req, 4'b0000, idx, 1'b0, 1'b0);
    add(1'b0, req, 4'b0000, idx, 1'b0, 1'b0);
  endfunction

  task automatic apply_a(input vec_t v, input string tag);
    @(negedge clk);
    rst_a = v.rst;
    req_a = v.req;
    @(posedge clk);
    #1;
    chk({tag, " grant"}, {28'd0, grant_a}, {28'd0, v.g});
    chk({tag, " idx"},   {30'd0, idx_a},   {30'd0, v.idx});
    chk({tag, " busy"},  {31'd0, busy_a},  {31'd0, v.busy});
    chk({tag, " slot_end"}, {31'd0, end_a}, {31'd0, v.send});
  endtask

  logic [3:0] seq_g[4];
  logic [1:0] seq_i[4];

  initial begin
    rst_a = 1'b1; req_a = 4'b0000;
    rst_b = 1'b1; req_b = 4'b0000;

    // Reset with all requesting, then first grant one edge after release.
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Full rotation 0,1,2,3 and wrap back to 0.
    add_slot(4'b1111, 4'b0001, 2'd0); add_gap(4'b1111, 2'd0);
    add_slot(4'b1111, 4'b0010, 2'd1); add_gap(4'b1111, 2'd1);
    add_slot(4'b1111, 4'b0100, 2'd2); add_gap(4'b1111, 2'd2);
    add_slot(4'b1111, 4'b1000, 2'd3); add_gap(4'b1111, 2'd3);
    add_slot(4'b1111, 4'b0001, 2'd0);
    // Single requester repeatedly granted.
    add_gap(4'b0100, 2'd0);
    add_slot(4'b0100, 4'b0100, 2'd2); add_gap(4'b0100, 2'd2);
    add_slot(4'b0100, 4'b0100, 2'd2);
    // Early release after 3 grant cycles: no slot_end pulse, back to idle.
    add_gap(4'b0010, 2'd2);
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    // Reset at slot count 5 of the grant to index 2; ptr returns to 0.
    for (int c = 0; c < 6; c++) add(1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);

    foreach (vecs[n]) apply_a(vecs[n], $sformatf("row%0d", n));

    // Continue the 0010 slot to its timeout, then drop the owner's request
    // in the timeout cycle: still counts as a timeout end.
    for (int c = 1; c < 8; c++) begin
      vec_t v;
      v.rst = 1'b0; v.req = 4'b1010; v.g = 4'b0010; v.idx = 2'd1; v.busy = 1'b1; v.send = (c == 7);
      apply_a(v, $sformatf("cont%0d", c));
    end
    @(negedge clk);
    req_a = 4'b1000;
    #1;
    chk("coincide slot_end", {31'd0, end_a}, 32'd1);
    chk("coincide grant held", {28'd0, grant_a}, 32'h2);
    @(posedge clk); #1;
    chk("coincide guard grant", {28'd0, grant_a}, 32'h0);
    chk("coincide guard busy", {31'd0, busy_a}, 32'd0);
    @(posedge clk); #1;
    chk("coincide idle grant", {28'd0, grant_a}, 32'h0);
    @(posedge clk); #1;
    chk("after coincide grant", {28'd0, grant_a}, 32'h8);
    chk("after coincide idx", {30'd0, idx_a}, 32'd3);

    // No-guard instance: gapless hand-over, and a lone owner is re-granted.
    seq_g[0] = 4'b0001; seq_i[0] = 2'd0;
    seq_g[1] = 4'b0100; seq_i[1] = 2'd2;
    seq_g[2] = 4'b0001; seq_i[2] = 2'd0;
    seq_g[3] = 4'b0001; seq_i[3] = 2'd0;
    @(negedge clk);
    rst_b = 1'b1; req_b = 4'b0101;
    repeat (2) @(posedge clk);
    #1;
    chk("b reset grant", {28'd0, grant_b}, 32'h0);
    chk("b reset busy", {31'd0, busy_b}, 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        chk($sformatf("b s%0d c%0d grant", s, c), {28'd0, grant_b}, {28'd0, seq_g[s]});
        chk($sformatf("b s%0d c%0d idx", s, c), {30'd0, idx_b}, {30'd0, seq_i[s]});
        chk($sformatf("b s%0d c%0d busy", s, c), {31'd0, busy_b}, 32'd1);
        chk($sformatf("b s%0d c%0d slot_end", s, c), {31'd0, end_b}, {31'd0, c == 7});
        if (s == 2 && c == 3) req_b = 4'b0001;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
